conv_tile_sequencer: RTL and testbench
======================================

Name: conv_tile_sequencer

Overview:
- Control FSM that runs one convolution tile through the Frontend/Backend datapath.
- Each pass loads weights from the weight ROM into the weight register file, then streams input activations (IA) from the IA RAM through multipliers, adder tree and accumulator.
- After the last pass it drains the pipeline and writes the accumulated result back.
- Sits beside the control system; takes tile descriptors over a start/done handshake.

Parameters:
- WTS_ADDR_W, 4, weight BRAM/ROM address width
- IA_ADDR_W, 11, IA RAM address width
- OUT_ADDR_W, 5, output RAM address width (ram_address)
- PASS_W, 4, width of the pass count
- ADDER_LAT, 3, adder-tree latency in cycles, adder_enable to accumulator input (≥1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  tile request, sampled in IDLE only
- num_wts  in  WTS_ADDR_W+1  weight words per pass (0 = skip weight load)
- ia_base  in  IA_ADDR_W  first IA address of each pass
- ia_len  in  IA_ADDR_W+1  IA words per pass (0 = skip stream)
- num_passes  in  PASS_W  channel-group passes (0 treated as 1)
- out_addr  in  OUT_ADDR_W  result write address
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at tile completion
- enable_wts_rom  out  1  weight ROM read enable
- wts_bram_addr  out  WTS_ADDR_W  weight ROM address
- wts_rf_enable  out  1  weight register-file capture (ROM data valid)
- enable_ia_ram  out  1  IA RAM read enable
- address_ia  out  IA_ADDR_W  IA RAM address
- adder_enable  out  1  adder-tree input valid
- accumulator_reset  out  1  clear accumulator
- accumulator_enable  out  1  accumulator add
- accum_data_select  out  1  route accumulator to the output RAM write
- ram_address  out  OUT_ADDR_W  output RAM write address

Behaviour:
- Reset: FSM to IDLE next edge. All outputs 0; internal counters and delay lines cleared. Applies mid-operation: in-flight enables are dropped and no done pulse is issued.
- States: IDLE, LD_WTS, STREAM, FLUSH, WRBACK, DONE.
- IDLE: busy=0. When start=1, latch all descriptor inputs, set pass counter to 0 and pulse accumulator_reset=1 for that cycle. Next state is LD_WTS, or STREAM if num_wts=0.
- LD_WTS: enable_wts_rom=1 and wts_bram_addr=0..num_wts-1, one word per cycle. Next state is STREAM, or FLUSH if ia_len=0.
- wts_rf_enable is enable_wts_rom delayed 1 cycle (ROM read latency 1).
- STREAM: enable_ia_ram=1 and address_ia=ia_base+k for k=0..ia_len-1, summed modulo 2^IA_ADDR_W (wrap permitted).
- After the last IA word: if passes remain, increment the pass counter and go to LD_WTS (no accumulator_reset); otherwise go to FLUSH.
- adder_enable is enable_ia_ram delayed 1 cycle. accumulator_enable is adder_enable delayed ADDER_LAT cycles. These are shift-register delay lines that keep running across state changes.
- FLUSH: exactly ADDER_LAT+1 cycles so the last accumulator_enable has fired; then WRBACK.
- WRBACK: one cycle, accum_data_select=1, ram_address=latched out_addr; then DONE.
- DONE: done=1 for one cycle, busy=0; then IDLE.
- A start asserted while busy is ignored and not queued. A start on the DONE cycle is ignored; a start on the following IDLE cycle is accepted.
- Descriptor inputs may change freely after acceptance; only latched copies are used.
- address_ia and wts_bram_addr hold their last value when not enabled. ram_address holds its value.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined: adds output perf_cycles (32 bits). It clears on start acceptance, increments every busy cycle, and freezes at done, holding until the next start. It saturates at all-ones. Reset clears it to 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Single pass, ADDER_LAT=3, num_wts=4, ia_base=16, ia_len=8, num_passes=1, out_addr=5, start at cycle 0:
  - cycles 1-4: wts_bram_addr 0..3; cycles 2-5: wts_rf_enable.
  - cycles 5-12: address_ia 16..23; cycles 6-13: adder_enable; cycles 9-16: accumulator_enable.
  - cycle 17: accum_data_select=1 with ram_address=5; cycle 18: done=1.
- num_passes=3, num_wts=2, ia_len=4 -> three LD_WTS/STREAM pairs, 12 accumulator_enable cycles total, accumulator_reset exactly once (start cycle), a single done.
- ia_base=2046, ia_len=4 -> address_ia sequence 2046, 2047, 0, 1.
- num_wts=0 and ia_len=0 -> no enables at all; FLUSH 4 cycles, then WRBACK, then done 6 cycles after start.
- reset=1 during STREAM at cycle 8 -> from cycle 9 all outputs 0 and no done pulse; a new start is accepted afterwards.
- start pulsed during busy and on the DONE cycle -> ignored; SEQ_PERF_CNT_EN build: perf_cycles=18 after the first scenario.

Source files
------------

// File: rtl/conv_tile_sequencer.sv
// Convolution tile sequencer: weight load, IA streaming, pipeline flush and write-back per tile.
// Optional perf_cycles counter is enabled by defining SEQ_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for start, descriptor latched on acceptance
// LD_WTS | reading num_wts weight words from the ROM
// STREAM | reading ia_len IA words, then next pass or flush
// FLUSH  | ADDER_LAT+1 cycles until the last accumulate has fired
// WRBACK | route accumulator to output RAM at latched out_addr
// DONE   | one-cycle completion pulse
module conv_tile_sequencer #(
    parameter int WTS_ADDR_W = 4,
    parameter int IA_ADDR_W  = 11,
    parameter int OUT_ADDR_W = 5,
    parameter int PASS_W     = 4,
    parameter int ADDER_LAT  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WTS_ADDR_W:0]   num_wts,
    input  logic [IA_ADDR_W-1:0]  ia_base,
    input  logic [IA_ADDR_W:0]    ia_len,
    input  logic [PASS_W-1:0]     num_passes,
    input  logic [OUT_ADDR_W-1:0] out_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  enable_wts_rom,
    output logic [WTS_ADDR_W-1:0] wts_bram_addr,
    output logic                  wts_rf_enable,
    output logic                  enable_ia_ram,
    output logic [IA_ADDR_W-1:0]  address_ia,
    output logic                  adder_enable,
    output logic                  accumulator_reset,
    output logic                  accumulator_enable,
    output logic                  accum_data_select,
    output logic [OUT_ADDR_W-1:0] ram_address
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    localparam int CNT_W = ((IA_ADDR_W > WTS_ADDR_W) ? IA_ADDR_W : WTS_ADDR_W) + 1;

    typedef enum logic [2:0] {IDLE, LD_WTS, STREAM, FLUSH, WRBACK, DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [PASS_W-1:0]     pass_cnt;
    logic [PASS_W-1:0]     l_passes_m1;
    logic [WTS_ADDR_W:0]   l_num_wts;
    logic [IA_ADDR_W-1:0]  l_ia_base;
    logic [IA_ADDR_W:0]    l_ia_len;
    logic [OUT_ADDR_W-1:0] l_out_addr;
    logic [ADDER_LAT-1:0]  acc_dly;

    assign accumulator_enable = acc_dly[ADDER_LAT-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            pass_cnt          <= '0;
            l_passes_m1       <= '0;
            l_num_wts         <= '0;
            l_ia_base         <= '0;
            l_ia_len          <= '0;
            l_out_addr        <= '0;
            acc_dly           <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            enable_wts_rom    <= 1'b0;
            wts_bram_addr     <= '0;
            wts_rf_enable     <= 1'b0;
            enable_ia_ram     <= 1'b0;
            address_ia        <= '0;
            adder_enable      <= 1'b0;
            accumulator_reset <= 1'b0;
            accum_data_select <= 1'b0;
            ram_address       <= '0;
        end else begin
            accumulator_reset <= 1'b0;
            accum_data_select <= 1'b0;
            done              <= 1'b0;
            enable_wts_rom    <= 1'b0;
            enable_ia_ram     <= 1'b0;
            // Delay lines free-run so in-flight data drains through state changes.
            wts_rf_enable     <= enable_wts_rom;
            adder_enable      <= enable_ia_ram;
            acc_dly[0]        <= adder_enable;
            for (int i = 1; i < ADDER_LAT; i++)
                acc_dly[i] <= acc_dly[i-1];

            case (state)
                IDLE: begin
                    if (start) begin
                        l_num_wts         <= num_wts;
                        l_ia_base         <= ia_base;
                        l_ia_len          <= ia_len;
                        l_out_addr        <= out_addr;
                        l_passes_m1       <= (num_passes == '0) ? '0 : num_passes - PASS_W'(1);
                        pass_cnt          <= '0;
                        accumulator_reset <= 1'b1;
                        busy              <= 1'b1;
                        if (num_wts != '0) begin
                            state          <= LD_WTS;
                            enable_wts_rom <= 1'b1;
                            wts_bram_addr  <= '0;
                            cnt            <= CNT_W'(num_wts) - CNT_W'(1);
                        end else if (ia_len != '0) begin
                            state         <= STREAM;
                            enable_ia_ram <= 1'b1;
                            address_ia    <= ia_base;
                            cnt           <= CNT_W'(ia_len) - CNT_W'(1);
                        end else begin
                            state <= FLUSH;
                            cnt   <= CNT_W'(ADDER_LAT);
                        end
                    end
                end
                LD_WTS: begin
                    if (cnt != '0) begin
                        enable_wts_rom <= 1'b1;
                        wts_bram_addr  <= wts_bram_addr + WTS_ADDR_W'(1);
                        cnt            <= cnt - CNT_W'(1);
                    end else if (l_ia_len != '0) begin
                        state         <= STREAM;
                        enable_ia_ram <= 1'b1;
                        address_ia    <= l_ia_base;
                        cnt           <= CNT_W'(l_ia_len) - CNT_W'(1);
                    end else begin
                        state <= FLUSH;
                        cnt   <= CNT_W'(ADDER_LAT);
                    end
                end
                STREAM: begin
                    if (cnt != '0) begin
                        enable_ia_ram <= 1'b1;
                        address_ia    <= address_ia + IA_ADDR_W'(1);
                        cnt           <= cnt - CNT_W'(1);
                    end else if (pass_cnt != l_passes_m1) begin
                        pass_cnt <= pass_cnt + PASS_W'(1);
                        if (l_num_wts != '0) begin
                            state          <= LD_WTS;
                            enable_wts_rom <= 1'b1;
                            wts_bram_addr  <= '0;
                            cnt            <= CNT_W'(l_num_wts) - CNT_W'(1);
                        end else begin
                            enable_ia_ram <= 1'b1;
                            address_ia    <= l_ia_base;
                            cnt           <= CNT_W'(l_ia_len) - CNT_W'(1);
                        end
                    end else begin
                        state <= FLUSH;
                        cnt   <= CNT_W'(ADDER_LAT);
                    end
                end
                FLUSH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state             <= WRBACK;
                        accum_data_select <= 1'b1;
                        ram_address       <= l_out_addr;
                    end
                end
                WRBACK: begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    // Counts every non-idle cycle including DONE, then holds until the next accepted start.
    always_ff @(posedge clock) begin
        if (reset)
            perf_cycles <= '0;
        else if (state == IDLE) begin
            if (start)
                perf_cycles <= '0;
        end else if (perf_cycles != '1)
            perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Self-checking bench for conv_tile_sequencer: per-cycle trace compared against a pass-by-pass model.
module tb_conv_tile_sequencer;
    localparam int ADDER_LAT = 3;
    localparam int MAXC = 600;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  num_wts = '0;
    logic [10:0] ia_base = '0;
    logic [11:0] ia_len = '0;
    logic [3:0]  num_passes = '0;
    logic [4:0]  out_addr = '0;
    logic        busy, done, enable_wts_rom, wts_rf_enable, enable_ia_ram;
    logic [3:0]  wts_bram_addr;
    logic [10:0] address_ia;
    logic        adder_enable, accumulator_reset, accumulator_enable, accum_data_select;
    logic [4:0]  ram_address;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    int checks = 0;
    int errors = 0;

    bit m_ew [0:MAXC-1];
    bit m_ei [0:MAXC-1];
    bit m_sel[0:MAXC-1];
    int m_wa [0:MAXC-1];
    int m_ia [0:MAXC-1];

    conv_tile_sequencer #(.ADDER_LAT(ADDER_LAT)) dut (
        .clock(clock), .reset(reset), .start(start),
        .num_wts(num_wts), .ia_base(ia_base), .ia_len(ia_len),
        .num_passes(num_passes), .out_addr(out_addr),
        .busy(busy), .done(done),
        .enable_wts_rom(enable_wts_rom), .wts_bram_addr(wts_bram_addr),
        .wts_rf_enable(wts_rf_enable), .enable_ia_ram(enable_ia_ram),
        .address_ia(address_ia), .adder_enable(adder_enable),
        .accumulator_reset(accumulator_reset), .accumulator_enable(accumulator_enable),
        .accum_data_select(accum_data_select), .ram_address(ram_address)
`ifdef SEQ_PERF_CNT_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clock = ~clock;

    // Cycle k is the k-th clock period after the start-accepting edge.
    task automatic build_model(input int nw, input int base, input int len, input int np, output int n);
        int k = 1;
        int passes = (np == 0) ? 1 : np;
        for (int i = 0; i < MAXC; i++) begin
            m_ew[i] = 0; m_ei[i] = 0; m_sel[i] = 0; m_wa[i] = 0; m_ia[i] = 0;
        end
        for (int p = 0; p < passes; p++) begin
            for (int w = 0; w < nw; w++) begin
                m_ew[k] = 1; m_wa[k] = w; k++;
            end
            if (len == 0) break;
            for (int j = 0; j < len; j++) begin
                m_ei[k] = 1; m_ia[k] = (base + j) % 2048; k++;
            end
        end
        k += ADDER_LAT + 1;
        m_sel[k] = 1;
        n = k + 1;
    endtask

    task automatic run_tile(input int nw, input int base, input int len, input int np,
                            input int oa, input bit noise);
        int n, acc_cnt, rst_cnt, rst_pos, exp_acc;
        bit e_rf, e_ad, e_acc, e_busy, e_done;
        build_model(nw, base, len, np, n);
        acc_cnt = 0; rst_cnt = 0; rst_pos = 0;
        num_wts = 5'(nw); ia_base = 11'(base); ia_len = 12'(len);
        num_passes = 4'(np); out_addr = 5'(oa); start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        num_wts = 5'($urandom); ia_base = 11'($urandom); ia_len = 12'($urandom);
        num_passes = 4'($urandom); out_addr = 5'($urandom);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clock);
            e_rf   = (k >= 2) ? m_ew[k-1] : 1'b0;
            e_ad   = (k >= 2) ? m_ei[k-1] : 1'b0;
            e_acc  = (k >= 2 + ADDER_LAT) ? m_ei[k-1-ADDER_LAT] : 1'b0;
            e_busy = (k < n);
            e_done = (k == n);
            if (accumulator_enable) acc_cnt++;
            if (accumulator_reset) begin
                rst_cnt++;
                if (rst_pos == 0) rst_pos = k;
            end
            checks++;
            if (busy !== e_busy) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", k, busy, e_busy); end
            checks++;
            if (done !== e_done) begin errors++; $display("FAIL done cyc=%0d got=%b exp=%b", k, done, e_done); end
            checks++;
            if (enable_wts_rom !== m_ew[k]) begin errors++; $display("FAIL wts_rom_en cyc=%0d got=%b exp=%b", k, enable_wts_rom, m_ew[k]); end
            if (m_ew[k]) begin
                checks++;
                if (wts_bram_addr !== 4'(m_wa[k])) begin errors++; $display("FAIL wts_addr cyc=%0d got=%0d exp=%0d", k, wts_bram_addr, m_wa[k]); end
            end
            checks++;
            if (wts_rf_enable !== e_rf) begin errors++; $display("FAIL wts_rf_en cyc=%0d got=%b exp=%b", k, wts_rf_enable, e_rf); end
            checks++;
            if (enable_ia_ram !== m_ei[k]) begin errors++; $display("FAIL ia_en cyc=%0d got=%b exp=%b", k, enable_ia_ram, m_ei[k]); end
            if (m_ei[k]) begin
                checks++;
                if (address_ia !== 11'(m_ia[k])) begin errors++; $display("FAIL ia_addr cyc=%0d got=%0d exp=%0d", k, address_ia, m_ia[k]); end
            end
            checks++;
            if (adder_enable !== e_ad) begin errors++; $display("FAIL adder_en cyc=%0d got=%b exp=%b", k, adder_enable, e_ad); end
            checks++;
            if (accumulator_enable !== e_acc) begin errors++; $display("FAIL acc_en cyc=%0d got=%b exp=%b", k, accumulator_enable, e_acc); end
            checks++;
            if (accum_data_select !== m_sel[k]) begin errors++; $display("FAIL data_sel cyc=%0d got=%b exp=%b", k, accum_data_select, m_sel[k]); end
            if (m_sel[k]) begin
                checks++;
                if (ram_address !== 5'(oa)) begin errors++; $display("FAIL ram_addr cyc=%0d got=%0d exp=%0d", k, ram_address, oa); end
            end
`ifdef SEQ_PERF_CNT_EN
            if (k == n + 1) begin
                checks++;
                if (perf_cycles !== 32'(n)) begin errors++; $display("FAIL perf_cycles got=%0d exp=%0d", perf_cycles, n); end
            end
`endif
            if (k < n) start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            else if (k == n) start = noise;
            else start = 1'b0;
        end
        exp_acc = (len == 0) ? 0 : ((np == 0) ? 1 : np) * len;
        checks++;
        if (acc_cnt != exp_acc) begin errors++; $display("FAIL acc_en_count got=%0d exp=%0d", acc_cnt, exp_acc); end
        checks++;
        if (rst_cnt != 1 || rst_pos != 1) begin errors++; $display("FAIL acc_reset got count=%0d pos=%0d exp count=1 pos=1", rst_cnt, rst_pos); end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({busy, done, enable_wts_rom, wts_bram_addr, wts_rf_enable, enable_ia_ram, address_ia,
             adder_enable, accumulator_reset, accumulator_enable, accum_data_select, ram_address} !== '0) begin
            errors++;
            $display("FAIL %s outputs not all zero busy=%b done=%b wen=%b wa=%0d ien=%b ia=%0d add=%b acc=%b sel=%b ra=%0d",
                     tag, busy, done, enable_wts_rom, wts_bram_addr, enable_ia_ram, address_ia,
                     adder_enable, accumulator_enable, accum_data_select, ram_address);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_single_pass();
        run_tile(4, 16, 8, 1, 5, 1'b0);
    endtask

    task automatic test_multi_pass();
        run_tile(2, $urandom_range(0, 2047), 4, 3, $urandom_range(0, 31), 1'b0);
    endtask

    task automatic test_addr_wrap();
        run_tile($urandom_range(0, 16), 2046, 4, 1, 9, 1'b0);
    endtask

    task automatic test_empty();
        run_tile(0, 100, 0, 1, 17, 1'b0);
    endtask

    task automatic test_mid_reset();
        num_wts = 5'd4; ia_base = 11'd16; ia_len = 12'd8; num_passes = 4'd1; out_addr = 5'd5;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 8; k++) @(negedge clock);
        checks++;
        if (enable_ia_ram !== 1'b1 || address_ia !== 11'd19) begin
            errors++;
            $display("FAIL pre_reset_stream got en=%b addr=%0d exp en=1 addr=19", enable_ia_ram, address_ia);
        end
        reset = 1'b1;
        for (int k = 9; k <= 20; k++) begin
            @(negedge clock);
            check_all_zero("mid_reset");
            reset = 1'b0;
        end
        run_tile(3, 500, 5, 2, 21, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_tile(3, 2040, 10, 2, 7, 1'b1);
        run_tile(1, 33, 2, 0, 30, 1'b1);
        run_tile(0, 12, 6, 2, 3, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++)
            run_tile($urandom_range(0, 16), $urandom_range(0, 2047), $urandom_range(0, 20),
                     $urandom_range(0, 4), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_addr_wrap();
        test_empty();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
